// File: rtl/hazard_ctrl.sv
// Hazard controller for the 5-stage RV32I pipeline: stall/flush sequencing for load-use
// and LSU wait states, EX-stage forwarding selects and saturating stall/flush counters.
module hazard_ctrl #(
  parameter int         LOAD_STALL_CYC = 1,
  parameter logic [1:0] WB_SEL_LOAD    = 2'b01,
  parameter int         CNT_W          = 32
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [4:0]       rs1D,
  input  logic [4:0]       rs2D,
  input  logic [4:0]       rs1E,
  input  logic [4:0]       rs2E,
  input  logic [4:0]       rdE,
  input  logic             rd_wrenE,
  input  logic [1:0]       wb_selE,
  input  logic             insn_vldE,
  input  logic             pc_selE,
  input  logic [4:0]       rdM,
  input  logic             rd_wrenM,
  input  logic [4:0]       rdW,
  input  logic             rd_wrenW,
  input  logic             i_mem_busy,
  input  logic             i_cnt_clr,
  output logic             stallF,
  output logic             stallD,
  output logic             flushD,
  output logic             stallE,
  output logic             flushE,
  output logic             stallM,
  output logic [1:0]       fwd_aE,
  output logic [1:0]       fwd_bE,
  output logic [CNT_W-1:0] o_stall_cnt,
  output logic [CNT_W-1:0] o_flush_cnt
);

  localparam int BW = (LOAD_STALL_CYC > 1) ? $clog2(LOAD_STALL_CYC) + 1 : 1;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    LD_STALL = 2'd1,
    MEM_WAIT = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [BW-1:0]    bub_q, bub_d;
  logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;
  logic             flush_inc;
  logic             load_use, redirect;

  assign load_use = rd_wrenE & (wb_selE == WB_SEL_LOAD) & (rdE != 5'd0) &
                    ((rdE == rs1D) | (rdE == rs2D));
  assign redirect = pc_selE & insn_vldE;

  always_comb begin
    stallF    = 1'b0;
    stallD    = 1'b0;
    flushD    = 1'b0;
    stallE    = 1'b0;
    flushE    = 1'b0;
    stallM    = 1'b0;
    flush_inc = 1'b0;
    state_d   = state_q;
    bub_d     = bub_q;
    if (!i_rst_n) begin
      flushD = 1'b1;
      flushE = 1'b1;
    end else if (state_q == LD_STALL && !i_mem_busy) begin
      stallF = 1'b1;
      stallD = 1'b1;
      flushE = 1'b1;
      bub_d  = bub_q - BW'(1);
      if (bub_q == BW'(1)) state_d = RUN;
    end else if (i_mem_busy) begin
      // Busy LSU wins in every state; leftover load bubbles are dropped.
      stallF  = 1'b1;
      stallD  = 1'b1;
      stallE  = 1'b1;
      stallM  = 1'b1;
      bub_d   = '0;
      state_d = MEM_WAIT;
    end else if (redirect) begin
      flushD    = 1'b1;
      flushE    = 1'b1;
      flush_inc = 1'b1;
      state_d   = RUN;
    end else if (load_use) begin
      stallF = 1'b1;
      stallD = 1'b1;
      flushE = 1'b1;
      if (LOAD_STALL_CYC == 1) begin
        state_d = RUN;
      end else begin
        state_d = LD_STALL;
        bub_d   = BW'(LOAD_STALL_CYC - 1);
      end
    end else begin
      state_d = RUN;
    end
  end

  // MEM has priority over WB; x0 is never forwarded.
  always_comb begin
    fwd_aE = 2'b00;
    fwd_bE = 2'b00;
    if (i_rst_n) begin
      if (rd_wrenM && rdM != 5'd0 && rdM == rs1E)      fwd_aE = 2'b10;
      else if (rd_wrenW && rdW != 5'd0 && rdW == rs1E) fwd_aE = 2'b01;
      if (rd_wrenM && rdM != 5'd0 && rdM == rs2E)      fwd_bE = 2'b10;
      else if (rd_wrenW && rdW != 5'd0 && rdW == rs2E) fwd_bE = 2'b01;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q     <= RUN;
      bub_q       <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      bub_q   <= bub_d;
      if (i_cnt_clr) begin
        stall_cnt_q <= '0;
        flush_cnt_q <= '0;
      end else begin
        if (stallF && stall_cnt_q != '1)    stall_cnt_q <= stall_cnt_q + CNT_W'(1);
        if (flush_inc && flush_cnt_q != '1) flush_cnt_q <= flush_cnt_q + CNT_W'(1);
      end
    end
  end

  assign o_stall_cnt = stall_cnt_q;
  assign o_flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: instance a (1 bubble, 4-bit counters for saturation)
// and instance b (3 bubbles) share one stimulus stream.
module tb_hazard_ctrl;

  logic       i_clk = 1'b0;
  logic       i_rst_n;
  logic [4:0] rs1D, rs2D, rs1E, rs2E, rdE, rdM, rdW;
  logic       rd_wrenE, insn_vldE, pc_selE, rd_wrenM, rd_wrenW, i_mem_busy, i_cnt_clr;
  logic [1:0] wb_selE;

  logic        a_stallF, a_stallD, a_flushD, a_stallE, a_flushE, a_stallM;
  logic [1:0]  a_fwd_aE, a_fwd_bE;
  logic [3:0]  a_stall_cnt, a_flush_cnt;
  logic        b_stallF, b_stallD, b_flushD, b_stallE, b_flushE, b_stallM;
  logic [1:0]  b_fwd_aE, b_fwd_bE;
  logic [31:0] b_stall_cnt, b_flush_cnt;

  int n_checks = 0;
  int n_errors = 0;

  always #5 i_clk = ~i_clk;

  hazard_ctrl #(.LOAD_STALL_CYC(1), .WB_SEL_LOAD(2'b01), .CNT_W(4)) dut_a (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .rs1D(rs1D), .rs2D(rs2D), .rs1E(rs1E), .rs2E(rs2E),
    .rdE(rdE), .rd_wrenE(rd_wrenE), .wb_selE(wb_selE), .insn_vldE(insn_vldE),
    .pc_selE(pc_selE), .rdM(rdM), .rd_wrenM(rd_wrenM), .rdW(rdW), .rd_wrenW(rd_wrenW),
    .i_mem_busy(i_mem_busy), .i_cnt_clr(i_cnt_clr),
    .stallF(a_stallF), .stallD(a_stallD), .flushD(a_flushD), .stallE(a_stallE),
    .flushE(a_flushE), .stallM(a_stallM), .fwd_aE(a_fwd_aE), .fwd_bE(a_fwd_bE),
    .o_stall_cnt(a_stall_cnt), .o_flush_cnt(a_flush_cnt)
  );

  hazard_ctrl #(.LOAD_STALL_CYC(3), .WB_SEL_LOAD(2'b01), .CNT_W(32)) dut_b (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .rs1D(rs1D), .rs2D(rs2D), .rs1E(rs1E), .rs2E(rs2E),
    .rdE(rdE), .rd_wrenE(rd_wrenE), .wb_selE(wb_selE), .insn_vldE(insn_vldE),
    .pc_selE(pc_selE), .rdM(rdM), .rd_wrenM(rd_wrenM), .rdW(rdW), .rd_wrenW(rd_wrenW),
    .i_mem_busy(i_mem_busy), .i_cnt_clr(i_cnt_clr),
    .stallF(b_stallF), .stallD(b_stallD), .flushD(b_flushD), .stallE(b_stallE),
    .flushE(b_flushE), .stallM(b_stallM), .fwd_aE(b_fwd_aE), .fwd_bE(b_fwd_bE),
    .o_stall_cnt(b_stall_cnt), .o_flush_cnt(b_flush_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end else begin
      $display("  ok %s = %0d", tag, got);
    end
  endtask

  task automatic idle();
    rs1D = 0; rs2D = 0; rs1E = 0; rs2E = 0; rdE = 0; rdM = 0; rdW = 0;
    rd_wrenE = 0; wb_selE = 0; insn_vldE = 0; pc_selE = 0;
    rd_wrenM = 0; rd_wrenW = 0; i_mem_busy = 0; i_cnt_clr = 0;
  endtask

  // lw x5 in EX, dependent instruction in ID reads x5
  task automatic set_load();
    rd_wrenE = 1; wb_selE = 2'b01; rdE = 5; rs1D = 5; insn_vldE = 1;
  endtask

  initial begin
    idle();
    i_rst_n = 0;
    // Reset: busy and a forwarding match present, yet outputs are forced
    @(negedge i_clk); i_mem_busy = 1; rdM = 7; rd_wrenM = 1; rs1E = 7; #1;
    chk("rst_stallF", a_stallF, 0);
    chk("rst_stallM", a_stallM, 0);
    chk("rst_flushD", a_flushD, 1);
    chk("rst_flushE", a_flushE, 1);
    chk("rst_fwd_a", a_fwd_aE, 0);
    @(negedge i_clk); idle(); i_rst_n = 1; #1;
    chk("rst_stall_cnt", a_stall_cnt, 0);
    chk("rst_flush_cnt", a_flush_cnt, 0);
    chk("run_idle_flushD", a_flushD, 0);

    // Load-use: a bubbles 1 cycle, b bubbles 3 cycles
    @(negedge i_clk); idle(); set_load(); #1;
    chk("lu_a_stallF", a_stallF, 1);
    chk("lu_a_stallD", a_stallD, 1);
    chk("lu_a_flushE", a_flushE, 1);
    chk("lu_a_flushD", a_flushD, 0);
    chk("lu_b_stallF0", b_stallF, 1);
    @(negedge i_clk); idle(); #1;
    chk("lu_a_release", a_stallF, 0);
    chk("lu_a_stall_cnt", a_stall_cnt, 1);
    chk("lu_b_stallF1", b_stallF, 1);
    chk("lu_b_flushE1", b_flushE, 1);
    @(negedge i_clk); idle(); #1;
    chk("lu_b_stallF2", b_stallF, 1);
    chk("lu_b_cnt2", b_stall_cnt, 2);
    @(negedge i_clk); idle(); #1;
    chk("lu_b_release", b_stallF, 0);
    chk("lu_b_stall_cnt", b_stall_cnt, 3);

    // Load to x0 is not a hazard
    @(negedge i_clk); idle(); set_load(); rdE = 0; rs1D = 0; #1;
    chk("lu_x0_stallF", a_stallF, 0);

    // Redirect together with load-use: flush wins, no LD_STALL
    @(negedge i_clk); idle(); set_load(); pc_selE = 1; #1;
    chk("rd_a_flushD", a_flushD, 1);
    chk("rd_a_flushE", a_flushE, 1);
    chk("rd_a_stallF", a_stallF, 0);
    chk("rd_b_stallF", b_stallF, 0);
    @(negedge i_clk); idle(); #1;
    chk("rd_a_flush_cnt", a_flush_cnt, 1);
    chk("rd_b_flush_cnt", b_flush_cnt, 1);
    chk("rd_b_no_ldstall", b_stallF, 0);
    chk("rd_a_stall_cnt", a_stall_cnt, 1);

    // Clear wins over a same-cycle increment
    @(negedge i_clk); idle(); set_load(); i_cnt_clr = 1; #1;
    chk("clr_a_stallF", a_stallF, 1);
    @(negedge i_clk); idle(); #1;
    chk("clr_a_stall_cnt", a_stall_cnt, 0);
    chk("clr_a_flush_cnt", a_flush_cnt, 0);
    @(negedge i_clk); idle();

    // LSU busy 4 cycles with redirect held, redirect applied once afterwards
    for (int i = 0; i < 4; i++) begin
      @(negedge i_clk); idle(); i_mem_busy = 1; pc_selE = 1; insn_vldE = 1; #1;
      chk($sformatf("mw%0d_stallF", i), a_stallF, 1);
      chk($sformatf("mw%0d_stallM", i), a_stallM, 1);
      chk($sformatf("mw%0d_flushD", i), a_flushD, 0);
    end
    @(negedge i_clk); idle(); pc_selE = 1; insn_vldE = 1; #1;
    chk("mw_end_flushD", a_flushD, 1);
    chk("mw_end_flushE", a_flushE, 1);
    chk("mw_end_stallF", a_stallF, 0);
    @(negedge i_clk); idle(); #1;
    chk("mw_flush_cnt", a_flush_cnt, 1);
    chk("mw_stall_cnt", a_stall_cnt, 4);

    // Saturation of the 4-bit stall counter
    for (int i = 0; i < 20; i++) begin
      @(negedge i_clk); idle(); i_mem_busy = 1;
    end
    @(negedge i_clk); idle(); #1;
    chk("sat_stall_cnt", a_stall_cnt, 15);
    chk("sat_release", a_stallF, 0);

    // Busy during LD_STALL drops the remaining bubbles
    @(negedge i_clk); idle(); set_load(); #1;
    chk("ldb_b_stallF", b_stallF, 1);
    @(negedge i_clk); idle(); i_mem_busy = 1; #1;
    chk("ldb_b_stallM", b_stallM, 1);
    chk("ldb_b_stallE", b_stallE, 1);
    @(negedge i_clk); idle(); #1;
    chk("ldb_b_stallF_after", b_stallF, 0);
    chk("ldb_b_flushE_after", b_flushE, 0);

    // Forwarding
    @(negedge i_clk); idle(); rdM = 7; rdW = 7; rd_wrenM = 1; rd_wrenW = 1; rs1E = 7; rs2E = 0; #1;
    chk("fwd_a_mem", a_fwd_aE, 2'b10);
    chk("fwd_b_none", a_fwd_bE, 2'b00);
    rd_wrenM = 0; rs2E = 7; #1;
    chk("fwd_a_wb", a_fwd_aE, 2'b01);
    chk("fwd_b_wb", a_fwd_bE, 2'b01);
    rdM = 0; rd_wrenM = 1; rdW = 0; rs1E = 0; #1;
    chk("fwd_a_x0", a_fwd_aE, 2'b00);

    // Reset in the middle of LD_STALL
    @(negedge i_clk); idle(); i_cnt_clr = 1;
    @(negedge i_clk); idle(); set_load(); #1;
    chk("rl_b_stallF", b_stallF, 1);
    @(negedge i_clk); idle(); i_rst_n = 0; #1;
    chk("rl_b_cnt_before", b_stall_cnt, 1);
    chk("rl_b_flushD", b_flushD, 1);
    chk("rl_b_flushE", b_flushE, 1);
    chk("rl_b_stallF", b_stallF, 0);
    @(negedge i_clk); i_rst_n = 1; #1;
    chk("rl_b_stall_cnt", b_stall_cnt, 0);
    chk("rl_b_flush_cnt", b_flush_cnt, 0);
    chk("rl_b_run", b_stallF, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
